// File: rtl/dmem_arbiter.sv
// Two-port (A priority, B starvation-protected) arbiter and sequencer for a single-port data memory.
// Optional alignment checking with a_err/b_err outputs is enabled by defining DMEM_ARB_ALIGN_CHECK_EN.
module dmem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_write,
  input  logic [ADDR_WIDTH-1:0] a_address,
  input  logic [DATA_WIDTH-1:0] a_write_data,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_read_data,
  input  logic                  b_req,
  input  logic                  b_write,
  input  logic [ADDR_WIDTH-1:0] b_address,
  input  logic [DATA_WIDTH-1:0] b_write_data,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_read_data,
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  output logic                  a_err,
  output logic                  b_err,
`endif
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  busy
);

  localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic {IDLE, SERVE} state_e;

  state_e                  state_q, state_d;
  logic                    owner_b_q, owner_b_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    mem_write_q, mem_write_d;
  logic                    busy_q, busy_d;
  logic                    a_ack_q, a_ack_d;
  logic                    b_ack_q, b_ack_d;
  logic [DATA_WIDTH-1:0]   a_rd_q, a_rd_d;
  logic [DATA_WIDTH-1:0]   b_rd_q, b_rd_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic                    misal_q, misal_d;
  logic                    a_err_q, a_err_d;
  logic                    b_err_q, b_err_d;
`endif

  logic                    a_elig, b_elig, grant_b;
  logic                    sel_write, load_ok;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  // A port whose ack is currently high has just been served; its req is ignored
  assign a_elig    = a_req & ~a_ack_q;
  assign b_elig    = b_req & ~b_ack_q;
  assign grant_b   = b_elig & (~a_elig | (cnt_q == CNT_W'(STARVE_LIMIT)));
  assign sel_write = grant_b ? b_write      : a_write;
  assign sel_addr  = grant_b ? b_address    : a_address;
  assign sel_wdata = grant_b ? b_write_data : a_write_data;

  always_comb begin
    state_d     = state_q;
    owner_b_d   = owner_b_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_write_d = 1'b0;
    busy_d      = 1'b0;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    a_rd_d      = a_rd_q;
    b_rd_d      = b_rd_q;
    cnt_d       = cnt_q;
    load_ok     = 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    misal_d     = misal_q;
    a_err_d     = 1'b0;
    b_err_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (a_elig | b_elig) begin
          state_d   = SERVE;
          busy_d    = 1'b1;
          owner_b_d = grant_b;
          wr_d      = sel_write;
          addr_d    = sel_addr;
          wdata_d   = sel_wdata;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
          misal_d     = |sel_addr[1:0];
          mem_write_d = sel_write & ~(|sel_addr[1:0]);
`else
          mem_write_d = sel_write;
`endif
          if (grant_b) begin
            cnt_d = '0;
          end else if (b_elig && (cnt_q != CNT_W'(STARVE_LIMIT))) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      SERVE: begin
        state_d = IDLE;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        load_ok = ~wr_q & ~misal_q;
        a_err_d = ~owner_b_q & misal_q;
        b_err_d = owner_b_q & misal_q;
`else
        load_ok = ~wr_q;
`endif
        if (owner_b_q) begin
          b_ack_d = 1'b1;
          if (load_ok) b_rd_d = mem_read_data;
        end else begin
          a_ack_d = 1'b1;
          if (load_ok) a_rd_d = mem_read_data;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!b_req) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_b_q   <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rd_q      <= '0;
      b_rd_q      <= '0;
      cnt_q       <= '0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      misal_q     <= 1'b0;
      a_err_q     <= 1'b0;
      b_err_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_b_q   <= owner_b_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_write_q <= mem_write_d;
      busy_q      <= busy_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      a_rd_q      <= a_rd_d;
      b_rd_q      <= b_rd_d;
      cnt_q       <= cnt_d;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      misal_q     <= misal_d;
      a_err_q     <= a_err_d;
      b_err_q     <= b_err_d;
`endif
    end
  end

  assign a_ack          = a_ack_q;
  assign b_ack          = b_ack_q;
  assign a_read_data    = a_rd_q;
  assign b_read_data    = b_rd_q;
  assign mem_write      = mem_write_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign busy           = busy_q;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign a_err          = a_err_q;
  assign b_err          = b_err_q;
`endif

endmodule
